// File: rtl/router_pkg.sv
// Shared widths, header layout and the stored FIFO word for the router output FIFO.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package router_pkg;

  localparam int DW             = 8;
  localparam int DEPTH          = 16;
  localparam int AW             = $clog2(DEPTH);
  localparam int TIMEOUT_CYCLES = 30;
  localparam int HDR_LEN_MSB    = 7;
  localparam int HDR_LEN_LSB    = 2;
  localparam int PKT_CNT_W      = HDR_LEN_MSB - HDR_LEN_LSB + 1;

  typedef struct packed {
    logic          lfd;
    logic [DW-1:0] data;
  } fifo_word_t;

  // Bytes still owed after a header: payload length from the header plus the parity byte.
  function automatic logic [PKT_CNT_W-1:0] hdr_pkt_cnt(input logic [DW-1:0] hdr);
    return hdr[HDR_LEN_MSB:HDR_LEN_LSB] + PKT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/router_out_fifo_if.sv
// Bundle between the router FSM/destination driver and one output FIFO.
// Latency: n/a (wiring only).
// Backpressure: writer watches full, reader watches valid_out/empty.
interface router_out_fifo_if;
  import router_pkg::*;

  logic          write_enb;
  logic          lfd_state;
  logic [DW-1:0] data_in;
  logic          soft_reset;
  logic          read_enb;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          full;
  logic          empty;
  logic          pkt_done;
  logic          timeout;

  modport master (
    output write_enb, lfd_state, data_in, soft_reset, read_enb,
    input  data_out, valid_out, full, empty, pkt_done, timeout
  );

  modport slave (
    input  write_enb, lfd_state, data_in, soft_reset, read_enb,
    output data_out, valid_out, full, empty, pkt_done, timeout
  );

endinterface

// File: rtl/router_fifo_mem.sv
// Storage array for the output FIFO: one write port, one combinational read port.
// Latency: write lands at the clock edge; read data follows rd_addr_i with no clock.
// Backpressure: none here; the caller gates wr_en_i with full.
module router_fifo_mem
  import router_pkg::*;
(
  input  logic          clock,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  fifo_word_t    wr_word_i,
  input  logic [AW-1:0] rd_addr_i,
  output fifo_word_t    rd_word_o
);

  fifo_word_t mem_q [DEPTH];

  // Capture the pushed word; contents need no reset since pointers define validity.
  always_ff @(posedge clock) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_word_i;
  end

  assign rd_word_o = mem_q[rd_addr_i];

endmodule

// File: rtl/router_out_fifo.sv
// Per-port router output FIFO with packet-boundary tracking; optional idle self-flush (ROUTER_OUT_FIFO_TIMEOUT_EN).
// Latency: popped byte appears on data_out one cycle after read_enb; pkt_done one cycle after the parity byte shows.
// Backpressure: pushes while full and pops while empty are ignored; soft_reset/timeout flush beats both.
module router_out_fifo
  import router_pkg::*;
(
  input logic              clock,
  input logic              resetn,
  router_out_fifo_if.slave bus
);

  logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic [PKT_CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [DW-1:0]         data_out_q, data_out_d;
  logic                  done_pend_q, done_pend_d;
  logic                  pkt_done_q, pkt_done_d;
  logic                  timeout_q;
  logic                  timeout_hit;
  logic                  empty, full, push, pop, flush;
  fifo_word_t            rd_word;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = bus.write_enb && !full;
  assign pop   = bus.read_enb && !empty;
  assign flush = bus.soft_reset || timeout_hit;

  router_fifo_mem u_mem (
    .clock     (clock),
    .wr_en_i   (push && !flush),
    .wr_addr_i (wr_ptr_q[AW-1:0]),
    .wr_word_i ('{lfd: bus.lfd_state, data: bus.data_in}),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_word_o (rd_word)
  );

`ifdef ROUTER_OUT_FIFO_TIMEOUT_EN
  logic [4:0] idle_q, idle_d;

  // Count cycles where data waits unread; the final count triggers a self-flush.
  always_comb begin
    idle_d      = idle_q;
    timeout_hit = 1'b0;
    if (bus.soft_reset || empty || pop) begin
      idle_d = '0;
    end else if (idle_q == 5'(TIMEOUT_CYCLES - 1)) begin
      timeout_hit = 1'b1;
      idle_d      = '0;
    end else begin
      idle_d = idle_q + 5'd1;
    end
  end

  // Idle counter register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) idle_q <= '0;
    else         idle_q <= idle_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state for pointers, occupancy, packet counter and the output byte.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pkt_cnt_d   = pkt_cnt_q;
    data_out_d  = data_out_q;
    done_pend_d = 1'b0;
    pkt_done_d  = 1'b0;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      pkt_cnt_d  = '0;
      data_out_d = '0;
    end else begin
      pkt_done_d = done_pend_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) count_d = count_q + 1'b1;
      if (pop && !push) count_d = count_q - 1'b1;
      if (pop && rd_word.lfd) begin
        // A header starting the next packet overrides the end-of-packet clear.
        data_out_d = rd_word.data;
        pkt_cnt_d  = hdr_pkt_cnt(rd_word.data);
      end else begin
        if (done_pend_q) data_out_d = '0;
        else if (pop)    data_out_d = rd_word.data;
        if (pop && (pkt_cnt_q != '0)) begin
          pkt_cnt_d   = pkt_cnt_q - 1'b1;
          done_pend_d = (pkt_cnt_q == PKT_CNT_W'(1));
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pkt_cnt_q   <= '0;
      data_out_q  <= '0;
      done_pend_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pkt_cnt_q   <= pkt_cnt_d;
      data_out_q  <= data_out_d;
      done_pend_q <= done_pend_d;
      pkt_done_q  <= pkt_done_d;
      timeout_q   <= timeout_hit;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.valid_out = !empty;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.pkt_done  = pkt_done_q;
  assign bus.timeout   = timeout_q;

endmodule
